// File: rtl/mem_stage_sequencer.sv
// mem_stage_sequencer
// ---------------------------------------------------------------------------
// Purpose: runs the Memory-stage data access against a multi-cycle data
// memory. While an access is outstanding, Fetch, Decode, Execute and Memory
// are held, and a bubble is forced into the Memory-to-Writeback register.
// When the access completes, the captured load data is presented on ReadDataM
// for the single cycle in which the instruction advances to Writeback.
//
// Handshake: mem_req/mem_we/mem_addr/mem_wdata are registered. They stay
// stable from the edge that raises mem_req until the edge at which mem_ready
// is sampled high. That edge completes the transfer and drops mem_req.
// mem_ready is ignored whenever mem_req is low. mem_rdata is only meaningful
// alongside mem_ready.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   MemReadM, MemWriteM         load/store in Memory stage (both => store)
//   ALUOutM, WriteDataM         access byte address and store data
//   mem_req, mem_we             registered request / write enable
//   mem_addr, mem_wdata         registered address / store data
//   mem_ready, mem_rdata        memory completion and load data
//   ReadDataM                   registered load result
//   StallF/D/E/M, FlushW        combinational hazard controls
//   MemFault                    sticky misalignment/timeout flag
//   fsm_state                   current sequencer state (observability)
// ---------------------------------------------------------------------------
module mem_stage_sequencer #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ReadDataM,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        FlushW,
   output logic        MemFault,
   output logic [1:0]  fsm_state
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Last count value tolerated without ready; the edge seeing it aborts.
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] counter;
   logic             acc;
   logic             hold;

   assign acc = MemReadM | MemWriteM;

   // The pipeline is held for the issue cycle and every wait cycle.
   // In DONE the instruction is released so it advances with ReadDataM valid.
   assign hold = ((state == IDLE) && acc) || (state == BUSY);

   assign StallF    = hold;
   assign StallD    = hold;
   assign StallE    = hold;
   assign StallM    = hold;
   assign FlushW    = hold;
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ReadDataM <= '0;
         counter   <= '0;
         MemFault  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (acc) begin
                  if (ALUOutM[1:0] == 2'b00) begin
                     mem_req   <= 1'b1;
                     mem_we    <= MemWriteM;
                     mem_addr  <= ALUOutM;
                     mem_wdata <= WriteDataM;
                     counter   <= '0;
                     state     <= BUSY;
                  end else begin
                     // Misaligned: never touch memory, complete with a fault.
                     MemFault  <= 1'b1;
                     ReadDataM <= '0;
                     state     <= DONE;
                  end
               end
            end
            BUSY: begin
               // Ready takes priority over the timeout on the same edge.
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  // The latched write enable decides load vs store, so an
                  // access with both controls set keeps ReadDataM unchanged.
                  if (!mem_we) begin
                     ReadDataM <= mem_rdata;
                  end
                  state <= DONE;
               end else if (counter == TIMEOUT_LAST) begin
                  mem_req   <= 1'b0;
                  ReadDataM <= '0;
                  MemFault  <= 1'b1;
                  state     <= DONE;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            DONE: begin
               // acc here still belongs to the completing instruction.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// tb_mem_stage_sequencer
// Directed bench for mem_stage_sequencer with TIMEOUT=4. Inputs change 1ns
// after a rising edge; outputs are checked 1ns after the edge (registered)
// or 1ns after inputs change (combinational stall/flush).
module tb_mem_stage_sequencer;

   logic        clk;
   logic        reset;
   logic        MemReadM;
   logic        MemWriteM;
   logic [31:0] ALUOutM;
   logic [31:0] WriteDataM;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] ReadDataM;
   logic        StallF;
   logic        StallD;
   logic        StallE;
   logic        StallM;
   logic        FlushW;
   logic        MemFault;
   logic [1:0]  fsm_state;

   int tests_run;
   int tests_failed;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   mem_stage_sequencer #(
      .TIMEOUT(4),
      .CNT_W  (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MemReadM  (MemReadM),
      .MemWriteM (MemWriteM),
      .ALUOutM   (ALUOutM),
      .WriteDataM(WriteDataM),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .ReadDataM (ReadDataM),
      .StallF    (StallF),
      .StallD    (StallD),
      .StallE    (StallE),
      .StallM    (StallM),
      .FlushW    (FlushW),
      .MemFault  (MemFault),
      .fsm_state (fsm_state)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // All four stalls and FlushW move together.
   task automatic chk_hold(input string tag, input logic exp);
      chk(tag, {27'd0, StallF, StallD, StallE, StallM, FlushW}, {27'd0, {5{exp}}});
   endtask

   task automatic set_acc(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
      MemReadM   = rd;
      MemWriteM  = wr;
      ALUOutM    = addr;
      WriteDataM = wdata;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset      = 1'b1;
      mem_ready  = 1'b0;
      mem_rdata  = 32'h0;
      set_acc(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();

      // Reset state
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_we", {31'd0, mem_we}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_rdata", ReadDataM, 32'd0);
      chk("rst_fault", {31'd0, MemFault}, 32'd0);
      chk("rst_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
      reset = 1'b0;
      tick();
      chk_hold("idle_nohold", 1'b0);

      // Load 0x10, ready on 3rd request cycle
      set_acc(1'b1, 1'b0, 32'h0000_0010, 32'h0);
      settle();
      chk_hold("ld_issue_hold", 1'b1);
      chk("ld_issue_req", {31'd0, mem_req}, 32'd0);
      tick();
      chk("ld_req1", {31'd0, mem_req}, 32'd1);
      chk("ld_addr", mem_addr, 32'h0000_0010);
      chk("ld_we", {31'd0, mem_we}, 32'd0);
      chk_hold("ld_hold1", 1'b1);
      tick();
      chk("ld_req2", {31'd0, mem_req}, 32'd1);
      chk_hold("ld_hold2", 1'b1);
      tick();
      chk("ld_req3", {31'd0, mem_req}, 32'd1);
      chk_hold("ld_hold3", 1'b1);
      mem_ready = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      settle();
      chk("ld_done_req", {31'd0, mem_req}, 32'd0);
      chk("ld_done_state", {30'd0, fsm_state}, {30'd0, S_DONE});
      chk("ld_done_data", ReadDataM, 32'hDEAD_BEEF);
      chk_hold("ld_done_hold", 1'b0);
      set_acc(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      chk("ld_back_idle", {30'd0, fsm_state}, {30'd0, S_IDLE});
      chk("ld_fault", {31'd0, MemFault}, 32'd0);

      // Store 0x20 with both controls set (treated as store), ready at once
      set_acc(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
      settle();
      chk_hold("st_issue_hold", 1'b1);
      tick();
      chk("st_req", {31'd0, mem_req}, 32'd1);
      chk("st_we", {31'd0, mem_we}, 32'd1);
      chk("st_addr", mem_addr, 32'h0000_0020);
      chk("st_wdata", mem_wdata, 32'h1234_5678);
      chk_hold("st_hold", 1'b1);
      mem_ready = 1'b1;
      mem_rdata = 32'hAAAA_5555;
      tick();
      mem_ready = 1'b0;
      settle();
      chk("st_done_req", {31'd0, mem_req}, 32'd0);
      chk("st_done_state", {30'd0, fsm_state}, {30'd0, S_DONE});
      chk("st_keep_data", ReadDataM, 32'hDEAD_BEEF);
      chk_hold("st_done_hold", 1'b0);
      set_acc(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Misaligned load 0x13
      set_acc(1'b1, 1'b0, 32'h0000_0013, 32'h0);
      settle();
      chk_hold("mis_hold", 1'b1);
      tick();
      chk("mis_req", {31'd0, mem_req}, 32'd0);
      chk("mis_state", {30'd0, fsm_state}, {30'd0, S_DONE});
      chk("mis_data", ReadDataM, 32'd0);
      chk("mis_fault", {31'd0, MemFault}, 32'd1);
      chk_hold("mis_done_hold", 1'b0);
      set_acc(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Good load after fault: fault must stay sticky
      set_acc(1'b1, 1'b0, 32'h0000_0040, 32'h0);
      tick();
      chk("good_req", {31'd0, mem_req}, 32'd1);
      mem_ready = 1'b1;
      mem_rdata = 32'h0BAD_F00D;
      tick();
      mem_ready = 1'b0;
      chk("good_data", ReadDataM, 32'h0BAD_F00D);
      chk("good_fault_sticky", {31'd0, MemFault}, 32'd1);
      set_acc(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Reset clears the sticky fault
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("fault_cleared", {31'd0, MemFault}, 32'd0);
      chk("fault_clr_data", ReadDataM, 32'd0);

      // Ready on the 4th request cycle coincides with timeout: ready wins
      set_acc(1'b1, 1'b0, 32'h0000_0050, 32'h0);
      tick();
      chk("co_req1", {31'd0, mem_req}, 32'd1);
      tick();
      tick();
      tick();
      chk("co_req4", {31'd0, mem_req}, 32'd1);
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_ready = 1'b0;
      chk("co_req_drop", {31'd0, mem_req}, 32'd0);
      chk("co_data", ReadDataM, 32'hCAFE_F00D);
      chk("co_fault", {31'd0, MemFault}, 32'd0);
      chk("co_state", {30'd0, fsm_state}, {30'd0, S_DONE});
      set_acc(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Timeout: mem_ready never asserted
      set_acc(1'b1, 1'b0, 32'h0000_0060, 32'h0);
      tick();
      chk("to_req1", {31'd0, mem_req}, 32'd1);
      tick();
      chk("to_req2", {31'd0, mem_req}, 32'd1);
      tick();
      chk("to_req3", {31'd0, mem_req}, 32'd1);
      tick();
      chk("to_req4", {31'd0, mem_req}, 32'd1);
      chk_hold("to_hold4", 1'b1);
      tick();
      chk("to_req_drop", {31'd0, mem_req}, 32'd0);
      chk("to_data", ReadDataM, 32'd0);
      chk("to_fault", {31'd0, MemFault}, 32'd1);
      chk_hold("to_resume", 1'b0);
      set_acc(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      chk("to_idle", {30'd0, fsm_state}, {30'd0, S_IDLE});

      // Reset on 2nd BUSY cycle, then a stray ready pulse
      set_acc(1'b1, 1'b0, 32'h0000_0070, 32'h0);
      tick();
      tick();
      chk("rb_busy2", {30'd0, fsm_state}, {30'd0, S_BUSY});
      reset = 1'b1;
      set_acc(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      reset = 1'b0;
      chk("rb_req", {31'd0, mem_req}, 32'd0);
      chk_hold("rb_hold", 1'b0);
      chk("rb_data", ReadDataM, 32'd0);
      chk("rb_fault", {31'd0, MemFault}, 32'd0);
      mem_ready = 1'b1;
      mem_rdata = 32'h1111_1111;
      tick();
      mem_ready = 1'b0;
      chk("rb_pulse_data", ReadDataM, 32'd0);
      chk("rb_pulse_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
      chk("rb_pulse_req", {31'd0, mem_req}, 32'd0);

      // Subsequent load completes normally
      set_acc(1'b1, 1'b0, 32'h0000_0080, 32'h0);
      tick();
      chk("post_req", {31'd0, mem_req}, 32'd1);
      chk("post_addr", mem_addr, 32'h0000_0080);
      mem_ready = 1'b1;
      mem_rdata = 32'h8765_4321;
      tick();
      mem_ready = 1'b0;
      chk("post_data", ReadDataM, 32'h8765_4321);
      chk("post_state", {30'd0, fsm_state}, {30'd0, S_DONE});
      set_acc(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      chk("post_idle", {30'd0, fsm_state}, {30'd0, S_IDLE});

      // Final report
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
